// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle signed multiply/divide sequencer:
// FSM states, op encodings, iteration count and counter width.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = DATA_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: a Booth add/sub plus arithmetic right shift for mult,
// or one restoring shift/subtract for div on operand magnitudes.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             op,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    // The extra accumulator bit lets the most negative multiplicand be subtracted without overflow.
    logic [WIDTH:0] m_ext_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_s;
    logic [WIDTH:0] diff_s;

    // Single Booth or restoring iteration
    always_comb begin
        m_ext_s  = {opnd[WIDTH-1], opnd};
        sum_s    = acc;
        rem_s    = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff_s   = rem_s - {1'b0, opnd};
        acc_nxt  = {(WIDTH+1){1'b0}};
        q_nxt    = {WIDTH{1'b0}};
        q_m1_nxt = 1'b0;
        if (op == OP_MULT) begin
            case ({q[0], q_m1})
                2'b01:   sum_s = acc + m_ext_s;
                2'b10:   sum_s = acc - m_ext_s;
                default: sum_s = acc;
            endcase
            {acc_nxt, q_nxt, q_m1_nxt} = {sum_s[WIDTH], sum_s, q};
        end else begin
            if (!diff_s[WIDTH]) begin
                acc_nxt = diff_s;
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = rem_s;
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
            q_m1_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multicycle signed multiply/divide sequencer producing HI/LO for the CPU.
// One iteration per clock; divide by zero is flagged instead of executed.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               op_r;
    logic [WIDTH:0]     acc_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               q_m1_r;
    logic               neg_q_r;
    logic               neg_rem_r;
    logic               done_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH:0]     acc_step_s;
    logic [WIDTH-1:0]   q_step_s;
    logic               q_m1_step_s;
    logic               div_by_zero_s;
    logic               accept_s;
    logic               last_iter_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return cond_neg(v, v[WIDTH-1]);
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_r),
        .acc      (acc_r),
        .q        (q_r),
        .q_m1     (q_m1_r),
        .opnd     (opnd_r),
        .acc_nxt  (acc_step_s),
        .q_nxt    (q_step_s),
        .q_m1_nxt (q_m1_step_s)
    );

    // Request decode and next-state logic
    always_comb begin
        div_by_zero_s = (op == OP_DIV) && (b == {WIDTH{1'b0}});
        accept_s      = start && !div_by_zero_s;
        last_iter_s   = (cnt_r == CNT_W'(ITER - 1));
        state_nxt_s   = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, iteration datapath, result and pulse registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= OP_MULT;
            acc_r      <= {(WIDTH+1){1'b0}};
            q_r        <= {WIDTH{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            q_m1_r     <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && div_by_zero_s) begin
                        div_zero_r <= 1'b1;
                    end else if (accept_s) begin
                        cnt_r  <= {CNT_W{1'b0}};
                        op_r   <= op;
                        acc_r  <= {(WIDTH+1){1'b0}};
                        q_m1_r <= 1'b0;
                        if (op == OP_MULT) begin
                            q_r       <= b;
                            opnd_r    <= a;
                            neg_q_r   <= 1'b0;
                            neg_rem_r <= 1'b0;
                        end else begin
                            q_r       <= mag(a);
                            opnd_r    <= mag(b);
                            neg_q_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_rem_r <= a[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    acc_r  <= acc_step_s;
                    q_r    <= q_step_s;
                    q_m1_r <= q_m1_step_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                end
                FIX: begin
                    done_r <= 1'b1;
                    // Quotient sign follows the operand signs, remainder follows the dividend.
                    if (op_r == OP_MULT) begin
                        hi_r <= acc_r[WIDTH-1:0];
                        lo_r <= q_r;
                    end else begin
                        hi_r <= cond_neg(acc_r[WIDTH-1:0], neg_rem_r);
                        lo_r <= cond_neg(q_r, neg_q_r);
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO come from a 64-bit
// reference model, queued at start and compared when done pulses.
module tb_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op_i  = 1'b0;
    logic [31:0] a_i   = 32'd0;
    logic [31:0] b_i   = 32'd0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];
    logic [63:0] last_res = 64'd0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op_i),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Returns {hi, lo}: full signed product, or {remainder, quotient} truncated toward zero.
    function automatic logic [63:0] model(input logic o, input logic [31:0] av, input logic [31:0] bv);
        longint      sa;
        longint      sbv;
        longint      r64;
        longint      qq;
        longint      rr;
        logic [63:0] res;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        if (o == 1'b0) begin
            r64 = sa * sbv;
            res = r64;
        end else begin
            qq  = sa / sbv;
            rr  = sa % sbv;
            res = {rr[31:0], qq[31:0]};
        end
        return res;
    endfunction

    task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                          input logic [31:0] bv, input bit disturb);
        logic [63:0] expv;
        sb.push_back(model(o, av, bv));
        op_i  = o;
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a_i   = ~av;
        b_i   = bv ^ 32'h5a5a_0001;
        for (int c = 1; c <= 33; c++) begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            check({tag, " done early"}, 64'(done), 64'd0);
            check({tag, " div_zero"}, 64'(div_zero), 64'd0);
            if (c == 17) begin
                check({tag, " hi/lo held"}, {hi, lo}, last_res);
            end
            if (disturb && c == 5) begin
                start = 1'b1;
                op_i  = ~o;
                a_i   = 32'h0000_0003;
                b_i   = 32'h0000_0000;
            end
            step();
            start = 1'b0;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy end"}, 64'(busy), 64'd0);
        check({tag, " div_zero end"}, 64'(div_zero), 64'd0);
        expv = sb.pop_front();
        check({tag, " hi"}, 64'(hi), 64'(expv[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(expv[31:0]));
        last_res = expv;
    endtask

    initial begin
        logic [31:0] av;
        logic [31:0] bv;

        reset = 1'b0;
        step();
        step();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        reset = 1'b1;
        step();

        run_op("mult 7*-3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
        check("mult 7*-3 table", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mult b2b -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("div 7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

        // Divide by zero with a prior result held in hi/lo
        op_i  = 1'b1;
        a_i   = 32'h0000_0005;
        b_i   = 32'h0000_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("divz pulse", 64'(div_zero), 64'd1);
        check("divz busy", 64'(busy), 64'd0);
        check("divz done", 64'(done), 64'd0);
        for (int c = 2; c <= 8; c++) begin
            step();
            check("divz pulse off", 64'(div_zero), 64'd0);
            check("divz busy later", 64'(busy), 64'd0);
            check("divz no done", 64'(done), 64'd0);
        end
        check("divz hi/lo held", {hi, lo}, last_res);

        run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mult disturbed", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            av = $urandom;
            bv = $urandom;
            if (bv == 32'd0) begin
                bv = 32'd1;
            end
            run_op("random", i[0], av, bv, 1'b0);
        end

        // Reset in the middle of a multiply, with a start in the same cycle
        op_i  = 1'b0;
        a_i   = 32'h0000_1234;
        b_i   = 32'h0000_5678;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            step();
        end
        reset = 1'b0;
        start = 1'b1;
        a_i   = 32'h0000_0009;
        step();
        reset = 1'b1;
        start = 1'b0;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset hi/lo", {hi, lo}, 64'd0);
        step();
        check("dropped start busy", 64'(busy), 64'd0);
        for (int c = 0; c < 40; c++) begin
            step();
            check("post reset no done", 64'(done), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
